spi2dac_ctrl: RTL

- Output stage directly downstream of the audio processor. Takes the 10-bit offset-binary sample the processor registers on sysclk, plus the per-sample strobe (the same data_valid tick).
- Serialises the sample as a 16-bit command frame to an MCP4911-class SPI DAC, then pulses the DAC latch (LDAC).
- Accepts one sample per strobe. Drops and flags any strobe that arrives while a frame is in flight.

---
 rtl/spi2dac_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi2dac_ctrl.sv
// Serialises a 10-bit offset-binary sample into a 16-bit MCP4911-style SPI
// command frame, then pulses the DAC latch; drops and flags overlapping strobes.
module spi2dac_ctrl #(
   parameter int   HALF   = 2,
   parameter logic BUF    = 1'b0,
   parameter logic GA_N   = 1'b1,
   parameter logic SHDN_N = 1'b1
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [9:0] data_in,
   output logic       dac_cs_n,
   output logic       dac_sck,
   output logic       dac_sdi,
   output logic       dac_ld_n,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   localparam int             CW       = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP,
      S_LATCH
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     bit_q, bit_d;
   logic           hi_q, hi_d;
   logic [15:0]    shreg_q, shreg_d;

   logic cs_n_q, cs_n_d;
   logic sck_q, sck_d;
   logic sdi_q, sdi_d;
   logic ld_n_q, ld_n_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic overrun_q, overrun_d;

   logic phase_end;

   assign phase_end = (cnt_q == CNT_LAST);

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      bit_d     = bit_q;
      hi_d      = hi_q;
      shreg_d   = shreg_q;
      done_d    = 1'b0;
      overrun_d = overrun_q | (load & busy_q);

      if (state_q != S_IDLE && !phase_end) begin
         cnt_d = cnt_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (load) begin
               shreg_d = {1'b0, BUF, GA_N, SHDN_N, data_in, 2'b00};
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (phase_end) begin
               state_d = S_SHIFT;
               bit_d   = 4'd15;
               hi_d    = 1'b0;
            end
         end
         S_SHIFT: begin
            // The next bit is presented on the same edge that drops sck.
            if (phase_end) begin
               if (!hi_q) begin
                  hi_d = 1'b1;
               end else begin
                  hi_d = 1'b0;
                  if (bit_q == 4'd0) begin
                     state_d = S_HOLD;
                  end else begin
                     bit_d   = bit_q - 4'd1;
                     shreg_d = {shreg_q[14:0], 1'b0};
                  end
               end
            end
         end
         S_HOLD: begin
            if (phase_end) state_d = S_GAP;
         end
         S_GAP: begin
            if (phase_end) state_d = S_LATCH;
         end
         S_LATCH: begin
            if (phase_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Pins are derived from the next state so they can be registered glitch-free.
      cs_n_d = !(state_d inside {S_SETUP, S_SHIFT, S_HOLD});
      sck_d  = (state_d == S_SHIFT) && hi_d;
      sdi_d  = (state_d == S_SETUP || state_d == S_SHIFT) ? shreg_d[15] : 1'b0;
      ld_n_d = (state_d != S_LATCH);
      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         hi_q      <= 1'b0;
         shreg_q   <= '0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         sdi_q     <= 1'b0;
         ld_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         hi_q      <= hi_d;
         shreg_q   <= shreg_d;
         cs_n_q    <= cs_n_d;
         sck_q     <= sck_d;
         sdi_q     <= sdi_d;
         ld_n_q    <= ld_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign dac_cs_n = cs_n_q;
   assign dac_sck  = sck_q;
   assign dac_sdi  = sdi_q;
   assign dac_ld_n = ld_n_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overrun  = overrun_q;

endmodule
